// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, FIFO toward decode.
// Optional FETCH_HALT_EN: a fetched 16'hFFFF stops further requests until a redirect.
module fetch_stage #(
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [15:0]   id_instr,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc_plus1
);

  localparam int            PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int            CW   = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD   = CW'(QDEPTH);
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d, count_calc;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [15:0]   instr_q [QDEPTH];
  logic [AW-1:0] ipc_q   [QDEPTH];
  logic          push, pop, space, issue, halt_block;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A response is only kept when it completes a live request and no redirect kills it.
  assign push       = (state_q == BUSY) && imem_ack && !redirect_valid;
  assign pop        = id_valid && id_ready;
  assign count_calc = count_q + CW'(push) - CW'(pop);
  assign space      = (count_calc < QD);

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid)
      halted_d = 1'b0;
    else if (push && (imem_rdata == 16'hFFFF))
      halted_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  // Using the next value stops the back-to-back issue on the very edge HALT is pushed.
  assign halt_block = halted_d;
`else
  assign halt_block = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; issue marks a new request starting at this edge
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && space && !halt_block) begin
          issue   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          if (redirect_valid)
            state_d = IDLE;
          else if (space && !halt_block)
            issue = 1'b1;
          else
            state_d = IDLE;
        end else if (redirect_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req    = (state_q != IDLE);
    imem_addr   = addr_q;
    id_valid    = (count_q != '0);
    id_instr    = instr_q[head_q];
    id_pc       = ipc_q[head_q];
    id_pc_plus1 = ipc_q[head_q] + AW'(1);
  end

  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = redirect_valid ? '0 : count_calc;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (issue) begin
        addr_d = pc_q;
        pc_d   = pc_q + AW'(1);
      end
      if (pop)  head_d = ptr_inc(head_q);
      if (push) tail_d = ptr_inc(tail_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Queue storage needs no reset; id_valid gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail_q] <= imem_rdata;
      ipc_q[tail_q]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected fetch addresses and
// decode entries, negedge monitors pop and compare; a second DUT covers RESET_PC=FFFF.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;

  logic        imem_req, imem_ack = 1'b0, redirect_valid = 1'b0, id_ready = 1'b0, id_valid;
  logic [15:0] imem_addr, imem_rdata = 16'h0, redirect_pc = 16'h0;
  logic [15:0] id_instr, id_pc, id_pc_plus1;

  logic        imem_req_b, imem_ack_b, id_ready_b = 1'b0, id_valid_b;
  logic [15:0] imem_addr_b, imem_rdata_b, id_instr_b, id_pc_b, id_pc_plus1_b;
  logic        redirect_valid_b = 1'b0;
  logic [15:0] redirect_pc_b = 16'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int pops = 0, acks = 0, pops_b = 0;
  int lat = 1;
  bit halt_mode = 1'b0;

  logic [15:0] exp_id_q[$];
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_b_q[$];

  fetch_stage #(.AW(16), .RESET_PC(16'h0000), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus1(id_pc_plus1)
  );

  fetch_stage #(.AW(16), .RESET_PC(16'hFFFF), .QDEPTH(2)) dut_b (
    .clk(clk), .reset(reset),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .id_ready(id_ready_b), .id_valid(id_valid_b), .id_instr(id_instr_b),
    .id_pc(id_pc_b), .id_pc_plus1(id_pc_plus1_b)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a, input bit hm);
    return (hm && a == 16'h0003) ? 16'hFFFF : (a ^ 16'hC3A5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory for DUT A: ack after 'lat' cycles of a held request.
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    if (reset || !imem_req) begin
      cyc      = 0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack) cyc = 1;
      else          cyc = cyc + 1;
      imem_ack = (cyc >= lat);
    end
    imem_rdata = mem_word(imem_addr, halt_mode);
  end

  // Memory for DUT B: single-cycle ack.
  assign imem_ack_b   = imem_req_b;
  assign imem_rdata_b = mem_word(imem_addr_b, 1'b0);

  always @(negedge clk) begin : mon_id
    logic [15:0] e;
    if (!reset && !redirect_valid && id_valid && id_ready) begin
      pops++;
      $display("id   pc=%04h instr=%04h pc+1=%04h", id_pc, id_instr, id_pc_plus1);
      if (exp_id_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL id_unexpected: got pc %04h, expected no entry", id_pc);
      end else begin
        e = exp_id_q.pop_front();
        check("id_pc", id_pc, e);
        check("id_instr", id_instr, mem_word(e, halt_mode));
        check("id_pc_plus1", id_pc_plus1, 16'(e + 16'd1));
      end
    end
  end

  always @(negedge clk) begin : mon_addr
    logic [15:0] e;
    if (!reset && imem_req && imem_ack) begin
      acks++;
      $display("imem addr=%04h rdata=%04h", imem_addr, imem_rdata);
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL imem_unexpected: got addr %04h, expected no request", imem_addr);
      end else begin
        e = exp_addr_q.pop_front();
        check("imem_addr", imem_addr, e);
      end
    end
  end

  logic        hold_pend = 1'b0;
  logic [15:0] hold_addr = 16'h0;
  always @(negedge clk) begin : mon_stable
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && imem_req) check("addr_stable", imem_addr, hold_addr);
      hold_pend = imem_req && !imem_ack;
      hold_addr = imem_addr;
    end
  end

  always @(negedge clk) begin : mon_b
    logic [15:0] e;
    if (!reset && id_valid_b && id_ready_b) begin
      pops_b++;
      $display("idB  pc=%04h instr=%04h pc+1=%04h", id_pc_b, id_instr_b, id_pc_plus1_b);
      if (exp_b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected: got pc %04h, expected no entry", id_pc_b);
      end else begin
        e = exp_b_q.pop_front();
        check("b_pc", id_pc_b, e);
        check("b_instr", id_instr_b, mem_word(e, 1'b0));
        check("b_pc_plus1", id_pc_plus1_b, 16'(e + 16'd1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_both(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_id_q.push_back(16'(start + 16'(i)));
      exp_addr_q.push_back(16'(start + 16'(i)));
    end
  endtask

  task automatic push_ids(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) exp_id_q.push_back(16'(start + 16'(i)));
  endtask

  task automatic push_addrs(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(16'(start + 16'(i)));
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    id_ready       = 1'b0;
    id_ready_b     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", id_valid, 1'b0);
    check("rst_addr_b", imem_addr_b, 16'hFFFF);
    tick(2);
    exp_id_q.delete();
    exp_addr_q.delete();
    exp_b_q.delete();
    pops      = 0;
    acks      = 0;
    pops_b    = 0;
    halt_mode = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic redirect_pulse(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin : stim
    int first_req, first_val, k;
    #1;

    // Streaming with a 1-cycle memory, plus RESET_PC=FFFF wrap on the second DUT
    lat = 1;
    do_reset();
    push_both(16'h0000, 30);
    exp_b_q.push_back(16'hFFFF);
    for (int i = 0; i < 29; i++) exp_b_q.push_back(16'(i));
    id_ready   = 1'b1;
    id_ready_b = 1'b1;
    first_req = -1;
    first_val = -1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (first_req < 0 && imem_req) first_req = c;
      if (first_val < 0 && id_valid) first_val = c;
    end
    check("p1_first_req_cycle", first_req, 1);
    check("p1_first_valid_cycle", first_val, 2);
    check("p1_enough_pops", pops >= 15, 1'b1);
    check("b_enough_pops", pops_b >= 15, 1'b1);

    // Backpressure: queue fills to two entries, then resumes at addr 2
    do_reset();
    lat = 1;
    push_both(16'h0000, 30);
    tick(8);
    check("p2_req_low", imem_req, 1'b0);
    check("p2_acks", acks, 2);
    check("p2_valid", id_valid, 1'b1);
    check("p2_head_pc", id_pc, 16'h0000);
    id_ready = 1'b1;
    tick(12);
    check("p2_enough_pops", pops >= 10, 1'b1);

    // Redirect while BUSY without ack -> DISCARD, old response dropped
    do_reset();
    lat = 3;
    id_ready = 1'b1;
    exp_addr_q.push_back(16'h0000);
    push_addrs(16'h0040, 32);
    push_ids(16'h0040, 32);
    k = 0;
    while (!imem_req && k < 10) begin tick(1); k++; end
    check("p3_req_seen", imem_req, 1'b1);
    redirect_pulse(16'h0040);
    check("p3_discard_req", imem_req, 1'b1);
    check("p3_discard_addr", imem_addr, 16'h0000);
    k = 0;
    while (!(imem_req && imem_addr == 16'h0040) && k < 12) begin
      check("p3_queue_empty", id_valid, 1'b0);
      tick(1);
      k++;
    end
    check("p3_new_addr", imem_addr, 16'h0040);
    tick(25);
    check("p3_enough_pops", pops >= 5, 1'b1);

    // Redirect in the same cycle as the ack
    do_reset();
    lat = 3;
    id_ready = 1'b1;
    exp_addr_q.push_back(16'h0000);
    push_addrs(16'h0080, 32);
    push_ids(16'h0080, 32);
    k = 0;
    while (!imem_ack && k < 10) begin tick(1); k++; end
    check("p4_ack_seen", imem_ack, 1'b1);
    redirect_pulse(16'h0080);
    check("p4_dropped", id_valid, 1'b0);
    check("p4_idle", imem_req, 1'b0);
    tick(25);
    check("p4_enough_pops", pops >= 5, 1'b1);

    // HALT word 16'hFFFF at address 3
    do_reset();
    lat = 1;
    halt_mode = 1'b1;
    id_ready  = 1'b1;
`ifdef FETCH_HALT_EN
    push_both(16'h0000, 4);
    tick(12);
    check("p6_halt_req_low", imem_req, 1'b0);
    check("p6_halt_acks", acks, 4);
    check("p6_halt_drained", pops, 4);
    check("p6_halt_empty", id_valid, 1'b0);
    push_both(16'h0010, 32);
    redirect_pulse(16'h0010);
    tick(10);
    check("p6_resume_pops", pops >= 10, 1'b1);
`else
    push_both(16'h0000, 30);
    tick(20);
    check("p6_no_halt_pops", pops >= 15, 1'b1);
`endif

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the instruction decoder/controller.
- Holds the PC and issues word-addressed reads to instruction memory over a req/ack handshake.
- Buffers returned 16-bit instructions in a small queue and presents them to decode with valid/ready.
- Accepts PC redirects from downstream (taken branch, call, ret) and flushes wrong-path instructions.

Parameters:
- AW, 16, PC / instruction-memory address width (word address).
- RESET_PC, 0, PC value after reset.
- QDEPTH, 2, instruction queue depth in entries (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  read request, held high until imem_ack
- imem_addr  output  AW  read address; stable while imem_req=1
- imem_ack  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  16  instruction word
- redirect_valid  input  1  load PC with redirect_pc and flush the queue
- redirect_pc  input  AW  new fetch address
- id_ready  input  1  decode accepts head entry
- id_valid  output  1  queue head valid
- id_instr  output  16  head instruction
- id_pc  output  AW  address of head instruction
- id_pc_plus1  output  AW  id_pc+1 mod 2^AW (return address for call)

Behaviour:
- Reset (async): pc=RESET_PC, state=IDLE, queue count=0, imem_req=0, imem_addr=RESET_PC, id_valid=0. A request in flight when reset asserts is abandoned; imem_req drops immediately.
- FSM, 3 states; imem_req=1 in BUSY and DISCARD, 0 in IDLE.
  - IDLE: if no redirect and count_next<QDEPTH, then imem_addr<=pc, pc<=pc+1, go BUSY. Otherwise stay.
  - BUSY, no ack: hold.
  - BUSY, ack, no redirect: push {imem_rdata, imem_addr}. If count_next<QDEPTH, start the next request in the same edge (imem_addr<=pc, pc<=pc+1) and stay BUSY; else go IDLE. A 1-cycle-ack memory therefore sustains 1 instruction/cycle.
  - BUSY, no ack, redirect: go DISCARD (address held stable).
  - BUSY, ack, redirect: response dropped; go IDLE.
  - DISCARD, no ack: hold. With ack: response dropped; go IDLE.
- count_next = count + push - pop, where pop = id_valid & id_ready.
- Redirect priority, any state: pc<=redirect_pc, count<=0 at end of cycle, no push that cycle. A redirect while in DISCARD only updates pc. The first request to redirect_pc issues from IDLE on the next cycle.
- Outputs during the redirect cycle are wrong-path; decode qualifies them with its own redirect.
- Queue: FIFO with head on id_*. id_valid=(count!=0). Push into a full queue cannot occur, because issue is gated on space. Simultaneous push and pop with count==QDEPTH is legal.
- Latency: ack at edge N makes id_valid=1 from cycle N+1 if the queue was empty.
- Wrap: pc and id_pc_plus1 wrap from 2^AW-1 to 0 with no flag.
- Max one outstanding request.

Optional Feature:
- Macro FETCH_HALT_EN.
  - Defined: a pushed instruction equal to 16'hFFFF (HALT) sets a sticky halted flag. While halted, no new request issues from IDLE or back-to-back; the queue still drains to decode. A redirect clears halted. Reset clears halted.
  - Undefined: 16'hFFFF is ordinary data; fetch never stops.

Test Plan:
- Reset with 1-cycle-ack memory, id_ready=1 -> imem_addr 0,1,2,...; id_valid from 2nd cycle after first req; id_pc 0,1,2 consecutive, id_pc_plus1=id_pc+1.
- id_ready=0, QDEPTH=2 -> exactly 2 entries fetched (pc=2), imem_req low; raising id_ready resumes at addr 2 with no loss or duplication.
- 3-cycle ack latency; redirect_valid pulse with redirect_pc=16'h0040 during BUSY -> state DISCARD, imem_addr unchanged until ack, rdata dropped, next req addr 0x0040, queue empty meanwhile.
- Redirect same cycle as ack -> ack data not in queue; next req addr=redirect_pc.
- RESET_PC=16'hFFFF -> fetch addrs FFFF then 0000; id_pc_plus1 for FFFF is 0000.
- FETCH_HALT_EN defined, memory returns FFFF at addr 3 -> no request beyond addr 3 (or 4 if already issued), entries drain; redirect to 0x10 resumes fetch.
